// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared constants for the multi-cycle RV32I control unit: state encodings,
// opcode values, datapath select encodings and the packed control-word layout.
package multi_cycle_control_unit_pkg;

  localparam logic [3:0] kStIf     = 4'd0;
  localparam logic [3:0] kStId     = 4'd1;
  localparam logic [3:0] kStExR    = 4'd2;
  localparam logic [3:0] kStExI    = 4'd3;
  localparam logic [3:0] kStExAddr = 4'd4;
  localparam logic [3:0] kStMemRd  = 4'd5;
  localparam logic [3:0] kStMemWr  = 4'd6;
  localparam logic [3:0] kStWbAlu  = 4'd7;
  localparam logic [3:0] kStWbMem  = 4'd8;
  localparam logic [3:0] kStExBr   = 4'd9;
  localparam logic [3:0] kStExJal  = 4'd10;
  localparam logic [3:0] kStExJalr = 4'd11;
  localparam logic [3:0] kStHalt   = 4'd12;

  typedef enum logic [3:0] {
    ST_IF      = kStIf,
    ST_ID      = kStId,
    ST_EX_R    = kStExR,
    ST_EX_I    = kStExI,
    ST_EX_ADDR = kStExAddr,
    ST_MEM_RD  = kStMemRd,
    ST_MEM_WR  = kStMemWr,
    ST_WB_ALU  = kStWbAlu,
    ST_WB_MEM  = kStWbMem,
    ST_EX_BR   = kStExBr,
    ST_EX_JAL  = kStExJal,
    ST_EX_JALR = kStExJalr,
    ST_HALT    = kStHalt
  } state_t;

  localparam logic [6:0] kOpR      = 7'b0110011;
  localparam logic [6:0] kOpImm    = 7'b0010011;
  localparam logic [6:0] kOpLoad   = 7'b0000011;
  localparam logic [6:0] kOpStore  = 7'b0100011;
  localparam logic [6:0] kOpBranch = 7'b1100011;
  localparam logic [6:0] kOpJal    = 7'b1101111;
  localparam logic [6:0] kOpJalr   = 7'b1100111;
  localparam logic [6:0] kOpEcall  = 7'b1110011;

  localparam logic [1:0] kSrcBRs2  = 2'd0;
  localparam logic [1:0] kSrcBImm  = 2'd1;
  localparam logic [1:0] kSrcBFour = 2'd2;

  localparam logic [1:0] kMemToRegAlu = 2'd0;
  localparam logic [1:0] kMemToRegMdr = 2'd1;
  localparam logic [1:0] kMemToRegPc4 = 2'd2;

  localparam logic [1:0] kPcSrcPlus4  = 2'd0;
  localparam logic [1:0] kPcSrcAluOut = 2'd1;
  localparam logic [1:0] kPcSrcAluRes = 2'd2;

  localparam logic [1:0] kAluOpAdd    = 2'd0;
  localparam logic [1:0] kAluOpBranch = 2'd1;
  localparam logic [1:0] kAluOpFunct  = 2'd2;

  typedef struct packed {
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       retire;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/multi_cycle_control_unit_mem_wait.sv
// Saturating counter of consecutive stalled memory cycles; raises a sticky
// timeout flag once the stall reaches kMaxMemWait cycles.
module multi_cycle_control_unit_mem_wait #(
  parameter int kMaxMemWait = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic request,
  input  logic ready,
  output logic timeout
);

  localparam int kCountWidth = $clog2(kMaxMemWait + 1);
  localparam logic [kCountWidth-1:0] kMaxCount = kCountWidth'(kMaxMemWait);

  logic [kCountWidth-1:0] count;

  // The flag is set on the same edge the count reaches its ceiling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      timeout <= 1'b0;
    end else if (request && !ready) begin
      if (count != kMaxCount) begin
        count <= count + 1'b1;
      end
      if (count == kMaxCount - 1'b1) begin
        timeout <= 1'b1;
      end
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Control FSM for the multi-cycle RV32I datapath: steps each instruction
// through fetch, decode, execute, memory and writeback and drives all strobes.
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
#(
  parameter int kOpcodeWidth = 7,
  parameter int kMaxMemWait  = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [kOpcodeWidth-1:0] opcode,
  input  logic                    bcond,
  input  logic                    halt_cond,
  input  logic                    mem_ready,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic                    mdr_write,
  output logic                    reg_write,
  output logic [1:0]              mem_to_reg,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              alu_op,
  output logic                    pc_write,
  output logic [1:0]              pc_source,
  output logic                    retire,
  output logic                    halted,
  output logic                    mem_timeout
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IF;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ctrl       = '0;
    case (state)
      ST_IF: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = mem_ready;
        if (mem_ready) begin
          next_state = ST_ID;
        end
      end
      ST_ID: begin
        ctrl.alu_src_b = kSrcBImm;
        ctrl.alu_op    = kAluOpAdd;
        case (opcode)
          kOpR:              next_state = ST_EX_R;
          kOpImm:            next_state = ST_EX_I;
          kOpLoad, kOpStore: next_state = ST_EX_ADDR;
          kOpBranch:         next_state = ST_EX_BR;
          kOpJal:            next_state = ST_EX_JAL;
          kOpJalr:           next_state = ST_EX_JALR;
          default: begin
            // ECALL without the exit condition retires like any unknown opcode.
            if (opcode == kOpEcall && halt_cond) begin
              next_state = ST_HALT;
            end else begin
              ctrl.pc_write  = 1'b1;
              ctrl.pc_source = kPcSrcPlus4;
              ctrl.retire    = 1'b1;
              next_state     = ST_IF;
            end
          end
        endcase
      end
      ST_EX_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = kSrcBRs2;
        ctrl.alu_op    = kAluOpFunct;
        next_state     = ST_WB_ALU;
      end
      ST_EX_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = kSrcBImm;
        ctrl.alu_op    = kAluOpFunct;
        next_state     = ST_WB_ALU;
      end
      ST_EX_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = kSrcBImm;
        ctrl.alu_op    = kAluOpAdd;
        next_state     = (opcode == kOpStore) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.mdr_write = mem_ready;
        if (mem_ready) begin
          next_state = ST_WB_MEM;
        end
      end
      ST_MEM_WR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
        if (mem_ready) begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = kPcSrcPlus4;
          ctrl.retire    = 1'b1;
          next_state     = ST_IF;
        end
      end
      ST_WB_ALU: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = kMemToRegAlu;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = kPcSrcPlus4;
        ctrl.retire     = 1'b1;
        next_state      = ST_IF;
      end
      ST_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = kMemToRegMdr;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = kPcSrcPlus4;
        ctrl.retire     = 1'b1;
        next_state      = ST_IF;
      end
      ST_EX_BR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = kSrcBRs2;
        ctrl.alu_op    = kAluOpBranch;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = bcond ? kPcSrcAluOut : kPcSrcPlus4;
        ctrl.retire    = 1'b1;
        next_state     = ST_IF;
      end
      ST_EX_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = kMemToRegPc4;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = kPcSrcAluOut;
        ctrl.retire     = 1'b1;
        next_state      = ST_IF;
      end
      ST_EX_JALR: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = kSrcBImm;
        ctrl.alu_op     = kAluOpAdd;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = kMemToRegPc4;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = kPcSrcAluRes;
        ctrl.retire     = 1'b1;
        next_state      = ST_IF;
      end
      ST_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: begin
        next_state = ST_IF;
      end
    endcase
  end

  // Reset masks the control word combinationally so nothing leaks out of IF.
  assign ctrl_out = reset_n ? ctrl : '0;

  assign i_or_d     = ctrl_out.i_or_d;
  assign mem_read   = ctrl_out.mem_read;
  assign mem_write  = ctrl_out.mem_write;
  assign ir_write   = ctrl_out.ir_write;
  assign mdr_write  = ctrl_out.mdr_write;
  assign reg_write  = ctrl_out.reg_write;
  assign mem_to_reg = ctrl_out.mem_to_reg;
  assign alu_src_a  = ctrl_out.alu_src_a;
  assign alu_src_b  = ctrl_out.alu_src_b;
  assign alu_op     = ctrl_out.alu_op;
  assign pc_write   = ctrl_out.pc_write;
  assign pc_source  = ctrl_out.pc_source;
  assign retire     = ctrl_out.retire;
  assign halted     = ctrl_out.halted;

  multi_cycle_control_unit_mem_wait #(
    .kMaxMemWait(kMaxMemWait)
  ) u_mem_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .request (ctrl.mem_read | ctrl.mem_write),
    .ready   (mem_ready),
    .timeout (mem_timeout)
  );

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Scoreboard bench for the multi-cycle control unit: random instruction stream
// checked per instruction against a cycle-count/strobe-count model, plus directed cases.
module tb_multi_cycle_control_unit;

  localparam logic [6:0] opR      = 7'b0110011;
  localparam logic [6:0] opImm    = 7'b0010011;
  localparam logic [6:0] opLoad   = 7'b0000011;
  localparam logic [6:0] opStore  = 7'b0100011;
  localparam logic [6:0] opBranch = 7'b1100011;
  localparam logic [6:0] opJal    = 7'b1101111;
  localparam logic [6:0] opJalr   = 7'b1100111;
  localparam logic [6:0] opEcall  = 7'b1110011;

  typedef struct {
    logic [6:0] op;
    logic       bc;
    logic       hc;
    int         ifWait;
    int         memWait;
  } instr_t;

  typedef struct {
    int         cycles;
    int         memReads;
    int         memWrites;
    int         irWrites;
    int         mdrWrites;
    int         regWrites;
    int         pcWrites;
    logic [1:0] memToReg;
    logic [1:0] pcSrc;
    logic       tmo;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       bcond = 1'b0;
  logic       halt_cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       i_or_d, mem_read, mem_write, ir_write, mdr_write, reg_write;
  logic [1:0] mem_to_reg, alu_src_b, alu_op, pc_source;
  logic       alu_src_a, pc_write, retire, halted, mem_timeout;

  logic [18:0] allOut;
  logic [9:0]  rtypeView;

  int vectors = 0;
  int miscompares = 0;

  instr_t instrQ[$];
  exp_t   expQ[$];
  logic   tmoModel = 1'b0;

  bit     drvEnable = 1'b0;
  bit     monEnable = 1'b0;
  bit     needNew = 1'b1;
  instr_t cur;
  int     waitCnt = 0;

  int         cyc = 0, nRd = 0, nWr = 0, nIr = 0, nMdr = 0, nReg = 0, nPc = 0;
  logic [1:0] seenM2r = '0, seenPcSrc = '0;
  exp_t       expRec;

  multi_cycle_control_unit #(
    .kOpcodeWidth(7),
    .kMaxMemWait (15)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .bcond      (bcond),
    .halt_cond  (halt_cond),
    .mem_ready  (mem_ready),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .mdr_write  (mdr_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_write   (pc_write),
    .pc_source  (pc_source),
    .retire     (retire),
    .halted     (halted),
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  assign allOut = {i_or_d, mem_read, mem_write, ir_write, mdr_write, reg_write, mem_to_reg,
                   alu_src_a, alu_src_b, alu_op, pc_write, pc_source, retire, halted, mem_timeout};
  assign rtypeView = {mem_read, ir_write, alu_src_a, alu_src_b, alu_op, reg_write, pc_write, retire};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic bc, input logic hc, input logic rdy);
    @(negedge clk);
    opcode    = op;
    bcond     = bc;
    halt_cond = hc;
    mem_ready = rdy;
    #2;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    checkOutput("reset_all_zero", 32'(allOut), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Per-instruction expectation derived from the instruction class and the memory stalls.
  function automatic exp_t refModel(input instr_t i, input logic tmoSoFar);
    exp_t e;
    bit   isMem;
    e.cycles    = 2 + i.ifWait;
    e.memReads  = 1 + i.ifWait;
    e.memWrites = 0;
    e.irWrites  = 1;
    e.mdrWrites = 0;
    e.regWrites = 0;
    e.pcWrites  = 1;
    e.memToReg  = 2'd0;
    e.pcSrc     = 2'd0;
    isMem = (i.op == opLoad) || (i.op == opStore);
    if (i.op == opR || i.op == opImm) begin
      e.cycles += 2;
      e.regWrites = 1;
    end else if (i.op == opLoad) begin
      e.cycles += 3 + i.memWait;
      e.memReads += 1 + i.memWait;
      e.mdrWrites = 1;
      e.regWrites = 1;
      e.memToReg = 2'd1;
    end else if (i.op == opStore) begin
      e.cycles += 2 + i.memWait;
      e.memWrites = 1 + i.memWait;
    end else if (i.op == opBranch) begin
      e.cycles += 1;
      e.pcSrc = i.bc ? 2'd1 : 2'd0;
    end else if (i.op == opJal) begin
      e.cycles += 1;
      e.regWrites = 1;
      e.memToReg = 2'd2;
      e.pcSrc = 2'd1;
    end else if (i.op == opJalr) begin
      e.cycles += 1;
      e.regWrites = 1;
      e.memToReg = 2'd2;
      e.pcSrc = 2'd2;
    end
    e.tmo = tmoSoFar || (i.ifWait >= 15) || (isMem && i.memWait >= 15);
    return e;
  endfunction

  task automatic pushInstr(input logic [6:0] op, input logic bc, input logic hc, input int ifw, input int memw);
    instr_t i;
    exp_t   e;
    i.op = op;
    i.bc = bc;
    i.hc = hc;
    i.ifWait = ifw;
    i.memWait = memw;
    e = refModel(i, tmoModel);
    tmoModel = e.tmo;
    instrQ.push_back(i);
    expQ.push_back(e);
  endtask

  function automatic int randWait();
    if ($urandom_range(0, 24) == 0) return int'($urandom_range(14, 16));
    return int'($urandom_range(0, 3));
  endfunction

  function automatic logic [6:0] randOpcode();
    logic [6:0] op;
    case ($urandom_range(0, 9))
      0: op = opR;
      1: op = opImm;
      2: op = opLoad;
      3: op = opStore;
      4: op = opBranch;
      5: op = opJal;
      6: op = opJalr;
      7: op = opEcall;
      default: begin
        do op = 7'($urandom_range(0, 127));
        while (op == opR || op == opImm || op == opLoad || op == opStore || op == opBranch ||
               op == opJal || op == opJalr || op == opEcall);
      end
    endcase
    return op;
  endfunction

  // Driver and memory responder: stalls each access by the instruction's wait budget.
  always @(negedge clk) begin
    if (drvEnable) begin
      if (needNew && instrQ.size() > 0) begin
        cur       = instrQ.pop_front();
        opcode    = cur.op;
        bcond     = cur.bc;
        halt_cond = cur.hc;
        needNew   = 1'b0;
        waitCnt   = 0;
      end
      if (needNew) begin
        mem_ready = 1'b0;
      end else if (mem_read || mem_write) begin
        if (waitCnt >= ((mem_read && !i_or_d) ? cur.ifWait : cur.memWait)) begin
          mem_ready = 1'b1;
          waitCnt   = 0;
        end else begin
          mem_ready = 1'b0;
          waitCnt++;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (retire) needNew = 1'b1;
    end
  end

  // Monitor: accumulates strobes per instruction and scores them at each retire.
  always @(negedge clk) begin
    #2;
    if (monEnable) begin
      cyc++;
      if (mem_read)  nRd++;
      if (mem_write) nWr++;
      if (ir_write)  nIr++;
      if (mdr_write) nMdr++;
      if (reg_write) begin nReg++; seenM2r = mem_to_reg; end
      if (pc_write)  begin nPc++;  seenPcSrc = pc_source; end
      checkOutput("rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
      if (retire) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_retire: got retire=1, expected no instruction pending at %0t", $time);
        end else begin
          expRec = expQ.pop_front();
          checkOutput("sb_cycles",     32'(cyc),        32'(expRec.cycles));
          checkOutput("sb_mem_reads",  32'(nRd),        32'(expRec.memReads));
          checkOutput("sb_mem_writes", 32'(nWr),        32'(expRec.memWrites));
          checkOutput("sb_ir_writes",  32'(nIr),        32'(expRec.irWrites));
          checkOutput("sb_mdr_writes", 32'(nMdr),       32'(expRec.mdrWrites));
          checkOutput("sb_reg_writes", 32'(nReg),       32'(expRec.regWrites));
          checkOutput("sb_pc_writes",  32'(nPc),        32'(expRec.pcWrites));
          checkOutput("sb_mem_to_reg", 32'(seenM2r),    32'(expRec.memToReg));
          checkOutput("sb_pc_source",  32'(seenPcSrc),  32'(expRec.pcSrc));
          checkOutput("sb_timeout",    32'(mem_timeout), 32'(expRec.tmo));
          checkOutput("sb_halted",     32'(halted),     32'd0);
        end
        cyc = 0; nRd = 0; nWr = 0; nIr = 0; nMdr = 0; nReg = 0; nPc = 0;
        seenM2r = '0;
        seenPcSrc = '0;
      end
    end
  end

  initial begin
    logic [6:0] op;
    logic [9:0] rExp[5];

    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    checkOutput("reset_outputs", 32'(allOut), 32'd0);

    pushInstr(opLoad, 1'b0, 1'b0, 3, 2);
    pushInstr(opBranch, 1'b1, 1'b0, 0, 0);
    pushInstr(opBranch, 1'b0, 1'b0, 0, 0);
    for (int n = 0; n < 80; n++) begin
      op = randOpcode();
      pushInstr(op, 1'($urandom_range(0, 1)), (op == opEcall) ? 1'b0 : 1'($urandom_range(0, 1)),
                randWait(), randWait());
    end

    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    drvEnable = 1'b1;
    monEnable = 1'b1;
    for (int c = 0; c < 6000 && expQ.size() != 0; c++) @(posedge clk);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    #1;
    drvEnable = 1'b0;
    monEnable = 1'b0;

    // R-type walk-through with memory always ready.
    rExp[0] = 10'b1_1_0_00_00_0_0_0;
    rExp[1] = 10'b0_0_0_01_00_0_0_0;
    rExp[2] = 10'b0_0_1_00_10_0_0_0;
    rExp[3] = 10'b0_0_0_00_00_1_1_1;
    rExp[4] = 10'b1_1_0_00_00_0_0_0;
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(opR, 1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("rtype_cycle%0d", i + 1), 32'(rtypeView), 32'(rExp[i]));
    end

    // Store stalled 20 cycles: timeout after 15 stalled edges, instruction still completes.
    doReset();
    applyStimulus(opStore, 1'b0, 1'b0, 1'b1);
    applyStimulus(opStore, 1'b0, 1'b0, 1'b0);
    applyStimulus(opStore, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(opStore, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("sw_write_held_%0d", k), 32'({mem_write, mem_read, i_or_d}), 32'(3'b101));
      checkOutput($sformatf("sw_timeout_%0d", k), 32'(mem_timeout), 32'(k >= 16));
    end
    applyStimulus(opStore, 1'b0, 1'b0, 1'b1);
    checkOutput("sw_complete", 32'({pc_write, retire, pc_source, mem_timeout}), 32'(5'b11_00_1));
    applyStimulus(opStore, 1'b0, 1'b0, 1'b0);
    checkOutput("sw_back_to_if", 32'({mem_read, i_or_d, mem_timeout}), 32'(3'b101));

    // ECALL with the exit condition parks the FSM until reset.
    doReset();
    applyStimulus(opEcall, 1'b0, 1'b1, 1'b1);
    applyStimulus(opEcall, 1'b0, 1'b1, 1'b0);
    checkOutput("ecall_decode", 32'({pc_write, retire, halted}), 32'd0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(opEcall, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
      checkOutput($sformatf("halt_frozen_%0d", k), 32'({pc_write, mem_read, mem_write, retire, halted}),
                  32'(5'b00001));
    end
    doReset();
    applyStimulus(opEcall, 1'b0, 1'b0, 1'b0);
    checkOutput("halt_cleared_by_reset", 32'({mem_read, i_or_d, halted}), 32'(3'b100));

    // Asynchronous reset in the middle of a load read.
    doReset();
    applyStimulus(opLoad, 1'b0, 1'b0, 1'b1);
    applyStimulus(opLoad, 1'b0, 1'b0, 1'b0);
    applyStimulus(opLoad, 1'b0, 1'b0, 1'b0);
    applyStimulus(opLoad, 1'b0, 1'b0, 1'b0);
    checkOutput("ld_mem_rd", 32'({mem_read, i_or_d, mdr_write}), 32'(3'b110));
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_zero", 32'(allOut), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(opLoad, 1'b0, 1'b0, 1'b1);
    checkOutput("restart_in_if", 32'({mem_read, i_or_d, pc_write, retire}), 32'(4'b1000));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
